parity_frame_controller: RTL and testbench

//  Sequences even-parity checking over framed serial traffic. Each frame is DATA_BITS data

---
 rtl/parity_frame_controller.sv | 93 +++++++++
 tb/tb_parity_frame_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/parity_frame_controller.sv
// Even-parity frame sequencer: receives DATA_BITS data bits plus one parity bit,
// captures the word, reports a verdict, idle timeout/restart aborts and a saturating error tally.
module parity_frame_controller #(
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 bit_valid,
   input  logic                 serial_in,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 parity_err,
   output logic                 frame_abort,
   output logic [DATA_BITS-1:0] data_out,
   output logic [CNT_W-1:0]     err_count
);

   localparam int BCW = $clog2(DATA_BITS + 2);
   localparam int ICW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t               state, state_nx;
   logic [BCW-1:0]       bit_cnt;
   logic [ICW-1:0]       idle_cnt;
   logic                 parity;
   logic [DATA_BITS-1:0] sh;
   logic                 take, close, timeout, restart, bad;

   always_comb begin
      restart = (state == RECV) && start;
      take    = (state == RECV) && !start && bit_valid;
      close   = take && (bit_cnt == BCW'(DATA_BITS));
      timeout = (state == RECV) && !start && !bit_valid && (idle_cnt == ICW'(TIMEOUT - 1));
      bad     = parity ^ serial_in;
      busy       = (state == RECV);
      frame_done = (state == DONE);
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RECV;
         RECV:    if (start)        state_nx = RECV;
                  else if (close)   state_nx = DONE;
                  else if (timeout) state_nx = IDLE;
         DONE:    state_nx = start ? RECV : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         parity      <= 1'b0;
         sh          <= '0;
         frame_abort <= 1'b0;
         parity_err  <= 1'b0;
         data_out    <= '0;
         err_count   <= '0;
      end else begin
         // Registered so the pulse lands in the cycle after the aborting edge,
         // which can never be a DONE cycle.
         frame_abort <= timeout || restart;
         if (start) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
            parity   <= 1'b0;
         end else if (take) begin
            if (bit_cnt < BCW'(DATA_BITS))
               sh <= (sh >> 1) | (DATA_BITS'(serial_in) << (DATA_BITS - 1));
            parity   <= parity ^ serial_in;
            bit_cnt  <= bit_cnt + 1'b1;
            idle_cnt <= '0;
         end else if (state == RECV) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
         if (close) begin
            data_out   <= sh;
            parity_err <= bad;
            if (bad && (err_count != {CNT_W{1'b1}}))
               err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed bench for parity_frame_controller (DATA_BITS=8, TIMEOUT=16, CNT_W=8).
module tb_parity_frame_controller;

   logic       clk = 1'b0;
   logic       reset, start, bit_valid, serial_in;
   logic       busy, frame_done, parity_err, frame_abort;
   logic [7:0] data_out, err_count;
   int         checks = 0;
   int         errors = 0;

   parity_frame_controller #(.DATA_BITS(8), .TIMEOUT(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
      .serial_in(serial_in), .busy(busy), .frame_done(frame_done),
      .parity_err(parity_err), .frame_abort(frame_abort),
      .data_out(data_out), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      serial_in = b;
      tick();
      bit_valid = 1'b0;
      serial_in = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) send_bit(d[i]);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_abort", frame_abort, 0);
      chk("rst_data", data_out, 0);
      chk("rst_errcnt", err_count, 0);

      // 1: reset mid-frame
      do_start();
      chk("t1_busy", busy, 1);
      send_data(8'hFF, 4);
      reset = 1'b1;
      tick();
      chk("t1_busy_rst", busy, 0);
      chk("t1_abort_rst", frame_abort, 0);
      chk("t1_data_rst", data_out, 0);
      reset = 1'b0;
      tick();
      chk("t1_abort_after", frame_abort, 0);
      chk("t1_idle", busy, 0);

      // 2: good frame 0xA5
      do_start();
      send_data(8'hA5, 8);
      chk("t2_not_done_yet", frame_done, 0);
      send_bit(1'b0);
      chk("t2_done", frame_done, 1);
      chk("t2_busy", busy, 0);
      chk("t2_data", data_out, 8'hA5);
      chk("t2_perr", parity_err, 0);
      chk("t2_errcnt", err_count, 0);
      tick();
      chk("t2_done_pulse", frame_done, 0);
      chk("t2_idle", busy, 0);

      // 3: bad frame 0x07 and saturation
      do_start();
      send_data(8'h07, 8);
      send_bit(1'b0);
      chk("t3_data", data_out, 8'h07);
      chk("t3_perr", parity_err, 1);
      chk("t3_errcnt", err_count, 1);
      for (int f = 0; f < 254; f++) begin
         do_start();
         send_data(8'h07, 8);
         send_bit(1'b0);
      end
      chk("t3_errcnt_255", err_count, 255);
      do_start();
      send_data(8'h07, 8);
      send_bit(1'b0);
      chk("t3_errcnt_sat", err_count, 255);
      chk("t3_perr_sat", parity_err, 1);

      // 4: idle timeout
      do_start();
      send_data(8'h07, 3);
      for (int i = 0; i < 15; i++) tick();
      chk("t4_no_abort_15", frame_abort, 0);
      chk("t4_busy_15", busy, 1);
      tick();
      chk("t4_abort", frame_abort, 1);
      chk("t4_busy", busy, 0);
      chk("t4_done", frame_done, 0);
      chk("t4_data_kept", data_out, 8'h07);
      chk("t4_perr_kept", parity_err, 1);
      tick();
      chk("t4_abort_pulse", frame_abort, 0);

      // 5: restart mid-frame
      do_start();
      send_data(8'hFF, 5);
      start = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
      tick();
      start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
      chk("t5_abort", frame_abort, 1);
      chk("t5_busy", busy, 1);
      send_data(8'h3C, 1);
      chk("t5_abort_pulse", frame_abort, 0);
      send_data(8'h3C >> 1, 7);
      send_bit(1'b0);
      chk("t5_done", frame_done, 1);
      chk("t5_data", data_out, 8'h3C);
      chk("t5_perr", parity_err, 0);
      chk("t5_errcnt", err_count, 255);

      // 6: back-to-back frames
      tick();
      do_start();
      send_data(8'h55, 8);
      send_bit(1'b0);
      chk("t6_done1", frame_done, 1);
      chk("t6_data1", data_out, 8'h55);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_b2b_busy", busy, 1);
      chk("t6_b2b_done", frame_done, 0);
      send_data(8'hFF, 8);
      send_bit(1'b0);
      chk("t6_done2", frame_done, 1);
      chk("t6_data2", data_out, 8'hFF);
      chk("t6_perr2", parity_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
